// File: rtl/stream_demux4_pkg.sv
// Shared constants and types for the four-way stream demultiplexer.
package stream_demux4_pkg;

  localparam int NUM_CH     = 4;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 8;

  typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/stream_demux4_slot.sv
// One output holding slot: a registered word plus valid flag, with an optional
// accept counter enabled by the STREAM_DEMUX4_CNT_EN macro.
module stream_demux4_slot #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
`ifdef STREAM_DEMUX4_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_cnt
`endif
);

  // A load takes priority over a drain so a same-edge drain/load refills without a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef STREAM_DEMUX4_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_load) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/stream_demux4.sv
// Routes one valid/ready input stream to four independent output slots chosen by i_ctlr.
// Define STREAM_DEMUX4_CNT_EN to add per-channel accept counters on o_cnt_0..o_cnt_3.
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  ch_sel_t           i_ctlr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid_0,
  output logic              o_valid_1,
  output logic              o_valid_2,
  output logic              o_valid_3,
  input  logic              i_ready_0,
  input  logic              i_ready_1,
  input  logic              i_ready_2,
  input  logic              i_ready_3,
  output logic [DATA_W-1:0] o_data_0,
  output logic [DATA_W-1:0] o_data_1,
  output logic [DATA_W-1:0] o_data_2,
  output logic [DATA_W-1:0] o_data_3
`ifdef STREAM_DEMUX4_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_cnt_0,
  output logic [CNT_W-1:0]  o_cnt_1,
  output logic [CNT_W-1:0]  o_cnt_2,
  output logic [CNT_W-1:0]  o_cnt_3
`endif
);

  logic [NUM_CH-1:0] slot_valid;
  logic [NUM_CH-1:0] ready_vec;
  logic [DATA_W-1:0] slot_data [NUM_CH];
  logic              accept;
`ifdef STREAM_DEMUX4_CNT_EN
  logic [CNT_W-1:0]  slot_cnt [NUM_CH];
`endif

  assign ready_vec = {i_ready_3, i_ready_2, i_ready_1, i_ready_0};

  // Only the addressed slot gates acceptance, so a stalled channel never blocks the others.
  assign o_ready = !i_rst && (!slot_valid[i_ctlr] || ready_vec[i_ctlr]);
  assign accept  = i_valid && o_ready;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
    stream_demux4_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (accept && (i_ctlr == ch_sel_t'(n))),
      .i_data  (i_data),
      .i_ready (ready_vec[n]),
      .o_valid (slot_valid[n]),
      .o_data  (slot_data[n])
`ifdef STREAM_DEMUX4_CNT_EN
      ,
      .o_cnt   (slot_cnt[n])
`endif
    );
  end

  assign o_valid_0 = slot_valid[0];
  assign o_valid_1 = slot_valid[1];
  assign o_valid_2 = slot_valid[2];
  assign o_valid_3 = slot_valid[3];
  assign o_data_0  = slot_data[0];
  assign o_data_1  = slot_data[1];
  assign o_data_2  = slot_data[2];
  assign o_data_3  = slot_data[3];

`ifdef STREAM_DEMUX4_CNT_EN
  assign o_cnt_0 = slot_cnt[0];
  assign o_cnt_1 = slot_cnt[1];
  assign o_cnt_2 = slot_cnt[2];
  assign o_cnt_3 = slot_cnt[3];
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Self-checking bench for stream_demux4: directed scenarios plus random traffic against
// a per-channel holding-slot model; counter checks run when STREAM_DEMUX4_CNT_EN is defined.
module tb_stream_demux4;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_ctlr;
  logic [DW-1:0] i_data;
  logic          o_valid_0, o_valid_1, o_valid_2, o_valid_3;
  logic          i_ready_0, i_ready_1, i_ready_2, i_ready_3;
  logic [DW-1:0] o_data_0, o_data_1, o_data_2, o_data_3;
`ifdef STREAM_DEMUX4_CNT_EN
  logic [CW-1:0] o_cnt_0, o_cnt_1, o_cnt_2, o_cnt_3;
`endif

  logic [3:0]    dut_valid;
  logic [DW-1:0] dut_data [4];
  logic [CW-1:0] dut_cnt  [4];

  bit            m_valid [4];
  logic [DW-1:0] m_data  [4];
  int unsigned   m_cnt   [4];

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  stream_demux4 #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_ctlr    (i_ctlr),
    .i_data    (i_data),
    .o_valid_0 (o_valid_0),
    .o_valid_1 (o_valid_1),
    .o_valid_2 (o_valid_2),
    .o_valid_3 (o_valid_3),
    .i_ready_0 (i_ready_0),
    .i_ready_1 (i_ready_1),
    .i_ready_2 (i_ready_2),
    .i_ready_3 (i_ready_3),
    .o_data_0  (o_data_0),
    .o_data_1  (o_data_1),
    .o_data_2  (o_data_2),
    .o_data_3  (o_data_3)
`ifdef STREAM_DEMUX4_CNT_EN
    ,
    .o_cnt_0   (o_cnt_0),
    .o_cnt_1   (o_cnt_1),
    .o_cnt_2   (o_cnt_2),
    .o_cnt_3   (o_cnt_3)
`endif
  );

  always_comb begin
    dut_valid   = {o_valid_3, o_valid_2, o_valid_1, o_valid_0};
    dut_data[0] = o_data_0;
    dut_data[1] = o_data_1;
    dut_data[2] = o_data_2;
    dut_data[3] = o_data_3;
`ifdef STREAM_DEMUX4_CNT_EN
    dut_cnt[0]  = o_cnt_0;
    dut_cnt[1]  = o_cnt_1;
    dut_cnt[2]  = o_cnt_2;
    dut_cnt[3]  = o_cnt_3;
`else
    dut_cnt[0]  = '0;
    dut_cnt[1]  = '0;
    dut_cnt[2]  = '0;
    dut_cnt[3]  = '0;
`endif
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    for (int n = 0; n < 4; n++) begin
      checkValue($sformatf("o_valid_%0d", n), 32'(dut_valid[n]), 32'(m_valid[n]));
      checkValue($sformatf("o_data_%0d", n), 32'(dut_data[n]), 32'(m_data[n]));
`ifdef STREAM_DEMUX4_CNT_EN
      checkValue($sformatf("o_cnt_%0d", n), 32'(dut_cnt[n]), m_cnt[n]);
`endif
    end
  endtask

  // One clock step: drive inputs, check o_ready, clock, advance the model, check outputs.
  task automatic applyStimulus(input bit rst, input bit v, input logic [1:0] ch,
                               input logic [DW-1:0] d, input logic [3:0] rdy);
    bit exp_ready;
    bit acc;
    @(negedge i_clk);
    i_rst   = rst;
    i_valid = v;
    i_ctlr  = ch;
    i_data  = d;
    {i_ready_3, i_ready_2, i_ready_1, i_ready_0} = rdy;
    #1;
    exp_ready = !rst && (!m_valid[ch] || rdy[ch]);
    checkValue("o_ready", 32'(o_ready), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge i_clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      if (rst) begin
        m_valid[n] = 1'b0;
        m_data[n]  = '0;
        m_cnt[n]   = 0;
      end else if (acc && ch == 2'(n)) begin
        m_valid[n] = 1'b1;
        m_data[n]  = d;
        m_cnt[n]   = (m_cnt[n] + 1) % (1 << CW);
      end else if (m_valid[n] && rdy[n]) begin
        m_valid[n] = 1'b0;
      end
    end
    checkOutput();
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ctlr = 2'd0; i_data = '0;
    {i_ready_3, i_ready_2, i_ready_1, i_ready_0} = 4'hF;
    for (int n = 0; n < 4; n++) begin
      m_valid[n] = 1'b0; m_data[n] = '0; m_cnt[n] = 0;
    end

    applyStimulus(1, 0, 2'd0, 16'h0000, 4'hF);
    applyStimulus(1, 1, 2'd1, 16'hFFFF, 4'hF);
    checkValue("reset_valid", 32'(dut_valid), 32'h0);

    // Basic routing, one word per channel on consecutive cycles
    applyStimulus(0, 1, 2'd0, 16'h1111, 4'hF);
    checkValue("route_ch0", 32'({dut_valid, dut_data[0]}), 32'h1_1111);
    applyStimulus(0, 1, 2'd1, 16'h2222, 4'hF);
    checkValue("route_ch1", 32'({dut_valid, dut_data[1]}), 32'h2_2222);
    applyStimulus(0, 1, 2'd2, 16'h3333, 4'hF);
    checkValue("route_ch2", 32'({dut_valid, dut_data[2]}), 32'h4_3333);
    applyStimulus(0, 1, 2'd3, 16'h4444, 4'hF);
    checkValue("route_ch3", 32'({dut_valid, dut_data[3]}), 32'h8_4444);
    applyStimulus(0, 0, 2'd0, 16'h0000, 4'hF);

    // Stall isolation on channel 2
    applyStimulus(0, 1, 2'd2, 16'hAAAA, 4'b1011);
    applyStimulus(0, 1, 2'd2, 16'hBBBB, 4'b1011);
    applyStimulus(0, 1, 2'd0, 16'hCCCC, 4'b1011);
    checkValue("stall_ch0", 32'(dut_data[0]), 32'hCCCC);
    checkValue("stall_ch2_hold", 32'({dut_valid[2], dut_data[2]}), 32'h1_AAAA);
    applyStimulus(0, 0, 2'd0, 16'h0000, 4'hF);

    // Simultaneous drain and load of channel 2
    applyStimulus(0, 1, 2'd2, 16'h0001, 4'hF);
    applyStimulus(0, 1, 2'd2, 16'h0002, 4'hF);
    checkValue("drain_load_ch2", 32'({dut_valid[2], dut_data[2]}), 32'h1_0002);
    applyStimulus(0, 0, 2'd0, 16'h0000, 4'hF);

    // Back-to-back throughput on channel 1
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 2'd1, 16'(16'h1000 + i), 4'hF);
      checkValue("b2b_ch1", 32'({dut_valid[1], dut_data[1]}), 32'h1_0000 | 32'(16'h1000 + i));
    end
    applyStimulus(0, 0, 2'd0, 16'h0000, 4'hF);

    // Reset mid-operation while channel 3 is stalled
    applyStimulus(0, 1, 2'd3, 16'h5A5A, 4'b0111);
    applyStimulus(0, 0, 2'd0, 16'h0000, 4'b0111);
    applyStimulus(1, 1, 2'd0, 16'h7777, 4'b0111);
    checkValue("rst_mid_ch3", 32'({dut_valid[3], dut_data[3]}), 32'h0_0000);
    applyStimulus(0, 1, 2'd1, 16'h9999, 4'hF);
    checkValue("post_rst_accept", 32'({dut_valid[1], dut_data[1]}), 32'h1_9999);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
    end

`ifdef STREAM_DEMUX4_CNT_EN
    // Counter wrap on channel 0
    applyStimulus(1, 0, 2'd0, 16'h0000, 4'hF);
    for (int i = 1; i <= 256; i++) begin
      applyStimulus(0, 1, 2'd0, 16'($urandom), 4'hF);
      if (i == 255) checkValue("cnt0_255", 32'(dut_cnt[0]), 32'd255);
    end
    checkValue("cnt0_wrap", 32'(dut_cnt[0]), 32'd0);
    checkValue("cnt_others", 32'({dut_cnt[1], dut_cnt[2], dut_cnt[3]}), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
